// File: rtl/motion_pkg.sv
// Shared types and constants for the motion bounding-box scan engine.
package motion_pkg;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_PREV,
    ST_WAIT_PREV,
    ST_REQ_CUR,
    ST_WAIT_CUR,
    ST_ACCUM,
    ST_FINISH
  } scan_state_t;

  localparam int PIX_PER_WORD     = 32;
  localparam int WORDS_PER_ROW    = 640 / PIX_PER_WORD;
  localparam int DEF_FRAME_HEIGHT = 480;

  // Opcode offsets relative to the instance's custom-instruction ID.
  localparam logic [7:0] SCAN_OP_OFFSET   = 8'd0;
  localparam logic [7:0] READ_Y_OP_OFFSET = 8'd1;

endpackage

// File: rtl/motion_word_span.sv
// Lowest/highest set-bit encoder for one 32-bit difference word.
module motion_word_span (
  input  logic [31:0] word,
  output logic [4:0]  lo_idx,
  output logic [4:0]  hi_idx,
  output logic        any_set
);

  // Priority scans from both ends; indices are 0 when the word is empty.
  always_comb begin
    lo_idx  = '0;
    hi_idx  = '0;
    any_set = |word;
    for (int i = 31; i >= 0; i--) begin
      if (word[i]) lo_idx = 5'(i);
    end
    for (int i = 0; i < 32; i++) begin
      if (word[i]) hi_idx = 5'(i);
    end
  end

endmodule

// File: rtl/motion_scan_controller.sv
// Full-frame motion bounding-box scan, driven from the CPU custom-instruction port.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for scan or read-Y opcode
// REQ_PREV   | requesting previous-frame word, held until grant
// WAIT_PREV  | waiting for previous-frame read data
// REQ_CUR    | requesting current-frame word, held until grant
// WAIT_CUR   | waiting for current-frame read data
// ACCUM      | fold XOR of the word pair into the box, step word position
// FINISH     | report X extent, return to IDLE
module motion_scan_controller
  import motion_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd1,
  parameter int         FRAME_WIDTH         = WORDS_PER_ROW * PIX_PER_WORD,
  parameter int         FRAME_HEIGHT        = DEF_FRAME_HEIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        busRequest,
  output logic [31:0] busAddress,
  input  logic        busGrant,
  input  logic        busDataValid,
  input  logic [31:0] busData
);

  localparam int WORDS = FRAME_WIDTH / PIX_PER_WORD;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [CW-1:0] LAST_COL  = CW'(WORDS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(FRAME_HEIGHT - 1);
  localparam logic [7:0]    SCAN_ID   = customInstructionId + SCAN_OP_OFFSET;
  localparam logic [7:0]    READ_Y_ID = customInstructionId + READ_Y_OP_OFFSET;

  scan_state_t   state;
  logic [31:0]   prev_base;
  logic [31:0]   cur_base;
  logic [31:0]   word_off;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   prev_word;
  logic [31:0]   cur_word;
  logic [9:0]    min_x;
  logic [9:0]    max_x;
  logic [8:0]    min_y;
  logic [8:0]    max_y;

  logic [31:0]   diff;
  logic [4:0]    span_lo;
  logic [4:0]    span_hi;
  logic          span_any;
  logic [9:0]    col_x;
  logic [9:0]    x_lo;
  logic [9:0]    x_hi;
  logic [8:0]    row_y;
  logic [9:0]    nxt_min_x;
  logic [9:0]    nxt_max_x;
  logic [8:0]    nxt_min_y;
  logic [8:0]    nxt_max_y;
  logic          last_word;

  assign diff = prev_word ^ cur_word;

  motion_word_span u_span (
    .word    (diff),
    .lo_idx  (span_lo),
    .hi_idx  (span_hi),
    .any_set (span_any)
  );

  // Box update candidate for the current word pair.
  always_comb begin
    col_x     = 10'({col, 5'b00000});
    x_lo      = col_x + 10'(span_lo);
    x_hi      = col_x + 10'(span_hi);
    row_y     = 9'(row);
    nxt_min_x = min_x;
    nxt_max_x = max_x;
    nxt_min_y = min_y;
    nxt_max_y = max_y;
    last_word = (col == LAST_COL) && (row == LAST_ROW);
    if (span_any) begin
      if (x_lo < min_x)  nxt_min_x = x_lo;
      if (x_hi > max_x)  nxt_max_x = x_hi;
      if (row_y < min_y) nxt_min_y = row_y;
      if (row_y > max_y) nxt_max_y = row_y;
    end
  end

  // Scan sequencer with registered CI and bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      result     <= '0;
      busRequest <= 1'b0;
      busAddress <= '0;
      prev_base  <= '0;
      cur_base   <= '0;
      word_off   <= '0;
      col        <= '0;
      row        <= '0;
      prev_word  <= '0;
      cur_word   <= '0;
      min_x      <= '1;
      max_x      <= '0;
      min_y      <= '1;
      max_y      <= '0;
    end else begin
      done   <= 1'b0;
      result <= '0;
      case (state)
        ST_IDLE: begin
          if (start && iseId == SCAN_ID) begin
            prev_base  <= valueA;
            cur_base   <= valueB;
            word_off   <= '0;
            col        <= '0;
            row        <= '0;
            min_x      <= '1;
            max_x      <= '0;
            min_y      <= '1;
            max_y      <= '0;
            busRequest <= 1'b1;
            busAddress <= valueA;
            state      <= ST_REQ_PREV;
          end else if (start && iseId == READ_Y_ID) begin
            done   <= 1'b1;
            result <= {7'b0, min_y, 7'b0, max_y};
          end
        end
        ST_REQ_PREV: begin
          if (busGrant) begin
            busRequest <= 1'b0;
            state      <= ST_WAIT_PREV;
          end
        end
        ST_WAIT_PREV: begin
          if (busDataValid) begin
            prev_word  <= busData;
            busRequest <= 1'b1;
            busAddress <= cur_base + word_off;
            state      <= ST_REQ_CUR;
          end
        end
        ST_REQ_CUR: begin
          if (busGrant) begin
            busRequest <= 1'b0;
            state      <= ST_WAIT_CUR;
          end
        end
        ST_WAIT_CUR: begin
          if (busDataValid) begin
            cur_word <= busData;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          min_x <= nxt_min_x;
          max_x <= nxt_max_x;
          min_y <= nxt_min_y;
          max_y <= nxt_max_y;
          if (last_word) begin
            state <= ST_FINISH;
          end else begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            word_off   <= word_off + 32'd4;
            busRequest <= 1'b1;
            busAddress <= prev_base + word_off + 32'd4;
            state      <= ST_REQ_PREV;
          end
        end
        ST_FINISH: begin
          done   <= 1'b1;
          result <= {6'b0, min_x, 6'b0, max_x};
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_scan_controller.sv
// Directed bench for motion_scan_controller on a reduced 128x8 frame.
module tb_motion_scan_controller;

  localparam int FW  = 128;
  localparam int FH  = 8;
  localparam int WPR = FW / 32;
  localparam int NW  = WPR * FH;
  localparam logic [7:0] SCAN_ID = 8'd1;
  localparam logic [7:0] RDY_ID  = 8'd2;

  typedef struct {
    string       nm;
    logic [31:0] pa;
    logic [31:0] pb;
    int          x0, y0, x1, y1;
    int          gd;
    int          ml;
    logic [31:0] ex;
    logic [31:0] ey;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  iseId = '0;
  logic [31:0] valueA = '0;
  logic [31:0] valueB = '0;
  logic        done;
  logic [31:0] result;
  logic        busRequest;
  logic [31:0] busAddress;
  logic        busGrant;
  logic        busDataValid;
  logic [31:0] busData;

  int total = 0;
  int bad = 0;

  logic [31:0] prev_mem [NW];
  logic [31:0] cur_mem  [NW];
  logic [31:0] base_prev = '0;
  logic [31:0] base_cur = '0;
  int          req_count;
  int          grant_delay = 0;
  int          max_lat = 1;

  motion_scan_controller #(
    .customInstructionId (SCAN_ID),
    .FRAME_WIDTH         (FW),
    .FRAME_HEIGHT        (FH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .iseId        (iseId),
    .valueA       (valueA),
    .valueB       (valueB),
    .done         (done),
    .result       (result),
    .busRequest   (busRequest),
    .busAddress   (busAddress),
    .busGrant     (busGrant),
    .busDataValid (busDataValid),
    .busData      (busData)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Bus arbiter + memory model; expected address comes from the request count.
  initial begin
    logic [31:0] hold;
    logic [31:0] want;
    int lat;
    int widx;
    busGrant = 1'b0;
    busDataValid = 1'b0;
    busData = '0;
    req_count = 0;
    forever begin
      @(negedge clk);
      busGrant = 1'b0;
      busDataValid = 1'b0;
      if (rst_n && busRequest) begin
        widx = req_count / 2;
        want = (((req_count % 2) == 0) ? base_prev : base_cur) + 32'(4 * widx);
        hold = busAddress;
        check("bus_addr", busAddress, want);
        for (int k = 0; k < grant_delay; k++) begin
          @(negedge clk);
          if (!rst_n) break;
          check("req_held", {31'b0, busRequest}, 32'd1);
          check("addr_held", busAddress, hold);
        end
        busGrant = 1'b1;
        @(negedge clk);
        busGrant = 1'b0;
        if (rst_n) check("req_drop", {31'b0, busRequest}, 32'd0);
        lat = (max_lat > 1) ? int'($urandom_range(max_lat, 1)) : 1;
        for (int k = 1; k < lat; k++) @(negedge clk);
        if (widx < NW) busData = ((req_count % 2) == 0) ? prev_mem[widx] : cur_mem[widx];
        else           busData = 32'hDEAD_BEEF;
        busDataValid = 1'b1;
        req_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    iseId = id;
    valueA = a;
    valueB = b;
    @(negedge clk);
    start = 1'b0;
    iseId = '0;
  endtask

  task automatic prep(input vec_t v);
    for (int i = 0; i < NW; i++) begin
      prev_mem[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
      cur_mem[i]  = prev_mem[i];
    end
    if (v.x0 >= 0) cur_mem[v.y0 * WPR + v.x0 / 32][v.x0 % 32] = ~cur_mem[v.y0 * WPR + v.x0 / 32][v.x0 % 32];
    if (v.x1 >= 0) cur_mem[v.y1 * WPR + v.x1 / 32][v.x1 % 32] = ~cur_mem[v.y1 * WPR + v.x1 / 32][v.x1 % 32];
    base_prev = v.pa;
    base_cur = v.pb;
    grant_delay = v.gd;
    max_lat = v.ml;
    @(negedge clk);
    req_count = 0;
  endtask

  task automatic read_y(input string nm, input logic [31:0] ey);
    start_op(RDY_ID, 32'h0, 32'h0);
    check({nm, "_rdy_done"}, {31'b0, done}, 32'd1);
    check({nm, "_rdy_result"}, result, ey);
    @(negedge clk);
    check({nm, "_rdy_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic finish_scan(input vec_t v);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      check({v.nm, "_result_idle"}, result, 32'h0);
      @(negedge clk);
    end
    if (!ok) begin
      check({v.nm, "_timeout"}, 32'h0, 32'h1);
    end else begin
      check({v.nm, "_result"}, result, v.ex);
      check({v.nm, "_pairs"}, 32'(req_count), 32'(2 * NW));
      @(negedge clk);
      check({v.nm, "_pulse"}, {31'b0, done}, 32'd0);
      read_y(v.nm, v.ey);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"same",      32'h1000_0000, 32'h2000_0000, -1, -1, -1, -1,  0, 1, 32'h03FF_0000, 32'h01FF_0000};
    vecs[1] = '{"one_bit",   32'h1000_0000, 32'h2000_0000, 103, 5, -1, -1,  0, 1, 32'h0067_0067, 32'h0005_0005};
    vecs[2] = '{"corners",   32'h0000_0400, 32'h0000_0800,  0, 0, 127, 7,   0, 1, 32'h0000_007F, 32'h0000_0007};
    vecs[3] = '{"stall",     32'h1000_0000, 32'hFFFF_FFF0, 45, 3, 70, 6,   10, 8, 32'h002D_0046, 32'h0003_0006};
    vecs[4] = '{"same_word", 32'h0004_0000, 32'h0008_0000, 67, 1, 94, 1,    0, 3, 32'h0043_005E, 32'h0001_0001};

    repeat (3) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_busreq", {31'b0, busRequest}, 32'd0);
    check("rst_busaddr", busAddress, 32'h0);
    rst_n = 1'b1;
    read_y("rst", 32'h01FF_0000);

    // Foreign opcodes must not start anything.
    start_op(8'd7, 32'h1, 32'h2);
    for (int c = 0; c < 4; c++) begin
      check("foreign_done", {31'b0, done}, 32'd0);
      check("foreign_result", result, 32'h0);
      check("foreign_req", {31'b0, busRequest}, 32'd0);
      @(negedge clk);
    end
    start_op(8'd0, 32'h1, 32'h2);
    check("foreign0_done", {31'b0, done}, 32'd0);
    check("foreign0_req", {31'b0, busRequest}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      prep(vecs[i]);
      start_op(SCAN_ID, vecs[i].pa, vecs[i].pb);
      finish_scan(vecs[i]);
    end

    // Scan and read-Y opcodes while busy are dropped.
    prep(vecs[1]);
    start_op(SCAN_ID, vecs[1].pa, vecs[1].pb);
    repeat (15) @(negedge clk);
    start_op(SCAN_ID, 32'hAAAA_0000, 32'hBBBB_0000);
    start_op(RDY_ID, 32'h0, 32'h0);
    finish_scan(vecs[1]);

    // Reset mid-scan aborts without done; a fresh scan then works.
    prep(vecs[2]);
    start_op(SCAN_ID, vecs[2].pa, vecs[2].pb);
    repeat (20) @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      if (busRequest) break;
      @(negedge clk);
    end
    check("abort_req_before", {31'b0, busRequest}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_async", {31'b0, busRequest}, 32'd0);
    check("abort_addr_async", busAddress, 32'h0);
    check("abort_done_async", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done}, 32'd0);
      check("abort_no_req", {31'b0, busRequest}, 32'd0);
    end
    read_y("abort", 32'h01FF_0000);
    prep(vecs[2]);
    start_op(SCAN_ID, vecs[2].pa, vecs[2].pb);
    finish_scan(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
